ramp_sequencer: RTL and testbench

- Central phase/speed controller for the LED fade ramps.
- Owns one shared step-rate counter and one 0..POS_MAX position counter per colour channel; channel k resets to phase offset k*PHASE_STEP.
- Accepts start/stop/speed/realign commands over a valid/ready interface, so every channel advances in lockstep and speed changes land cleanly on a step boundary.
- Position outputs feed the downstream trapezoid shaping logic.

---
 rtl/ramp_sequencer.sv | 158 +++++++++++++++
 tb/tb_ramp_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ramp_sequencer.sv
// Ramp sequencer: one shared step-rate counter drives NUM_CH phase-offset
// position counters (0..POS_MAX) in lockstep. Commands arrive over valid/ready.
// A speed change made while running is held as pending and applied on the
// next step boundary, so every step runs entirely at one rate.
module ramp_sequencer #(
    parameter int unsigned NUM_CH        = 3,
    parameter int unsigned POS_MAX       = 359,
    parameter int unsigned PHASE_STEP    = 120,
    parameter int unsigned DELAY_W       = 22,
    parameter int unsigned DEFAULT_DELAY = 41666
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [DELAY_W-1:0]    cmd_arg,
    output logic [NUM_CH*9-1:0]   pos_out,
    output logic                  step_tick,
    output logic                  running
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [1:0]         OpStart    = 2'd0;
    localparam logic [1:0]         OpStop     = 2'd1;
    localparam logic [1:0]         OpSetDelay = 2'd2;
    localparam logic [1:0]         OpAlign    = 2'd3;
    localparam logic [8:0]         PosMax     = 9'(POS_MAX);
    localparam logic [DELAY_W-1:0] DefDelay   = DELAY_W'(DEFAULT_DELAY);

    // Reset/realign phase offset of channel k.
    function automatic logic [8:0] reset_pos(input int unsigned k);
        return 9'((k * PHASE_STEP) % (POS_MAX + 1));
    endfunction

    state_e               state_q, state_d;
    logic [DELAY_W-1:0]   counter_q, counter_d;
    logic [DELAY_W-1:0]   active_delay_q, active_delay_d;
    logic [DELAY_W-1:0]   pending_delay_q, pending_delay_d;
    logic                 delay_pending_q, delay_pending_d;
    logic [8:0]           pos_q [NUM_CH];
    logic [8:0]           pos_d [NUM_CH];
    logic                 step_tick_q, step_tick_d;
    logic                 running_q;

    logic accept, is_run, do_start, do_stop, do_set, do_align, boundary;

    // Command decode; STOP and ALIGN both pre-empt a coincident step boundary.
    always_comb begin
        cmd_ready = !delay_pending_q;
        accept    = cmd_valid && cmd_ready;
        is_run    = (state_q == StRun);
        do_start  = accept && (cmd_op == OpStart) && !is_run;
        do_stop   = accept && (cmd_op == OpStop) && is_run;
        do_set    = accept && (cmd_op == OpSetDelay);
        do_align  = accept && (cmd_op == OpAlign);
        boundary  = is_run && (counter_q >= active_delay_q) && !do_stop && !do_align;
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (do_start) state_d = StRun;
            StRun:   if (do_stop)  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath next state: counter, positions, delay bookkeeping, tick.
    always_comb begin
        counter_d       = counter_q;
        active_delay_d  = active_delay_q;
        pending_delay_d = pending_delay_q;
        delay_pending_d = delay_pending_q;
        step_tick_d     = 1'b0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            pos_d[k] = pos_q[k];
        end

        if (do_align) begin
            counter_d = '0;
            for (int k = 0; k < int'(NUM_CH); k++) begin
                pos_d[k] = reset_pos(k);
            end
        end else if (boundary) begin
            counter_d   = '0;
            step_tick_d = 1'b1;
            for (int k = 0; k < int'(NUM_CH); k++) begin
                pos_d[k] = (pos_q[k] == PosMax) ? 9'd0 : pos_q[k] + 9'd1;
            end
            if (delay_pending_q) begin
                active_delay_d  = pending_delay_q;
                delay_pending_d = 1'b0;
            end
        end else if (is_run && !do_stop) begin
            counter_d = counter_q + 1'b1;
        end

        // Leaving RUN must never strand a pending delay.
        if (do_stop && delay_pending_q) begin
            active_delay_d  = pending_delay_q;
            delay_pending_d = 1'b0;
        end

        if (do_set) begin
            if (is_run) begin
                pending_delay_d = cmd_arg;
                delay_pending_d = 1'b1;
            end else begin
                active_delay_d = cmd_arg;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_q       <= '0;
            active_delay_q  <= DefDelay;
            pending_delay_q <= '0;
            delay_pending_q <= 1'b0;
            step_tick_q     <= 1'b0;
            running_q       <= 1'b0;
            for (int k = 0; k < int'(NUM_CH); k++) begin
                pos_q[k] <= reset_pos(k);
            end
        end else begin
            counter_q       <= counter_d;
            active_delay_q  <= active_delay_d;
            pending_delay_q <= pending_delay_d;
            delay_pending_q <= delay_pending_d;
            step_tick_q     <= step_tick_d;
            running_q       <= (state_d == StRun);
            for (int k = 0; k < int'(NUM_CH); k++) begin
                pos_q[k] <= pos_d[k];
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_pos
        assign pos_out[9*g +: 9] = pos_q[g];
    end

    assign step_tick = step_tick_q;
    assign running   = running_q;

endmodule

// File: tb/tb_ramp_sequencer.sv
// Directed bench for ramp_sequencer (default parameters: 3 channels, 0..359).
module tb_ramp_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [21:0] cmd_arg = '0;
    logic [26:0] pos_out;
    logic        step_tick;
    logic        running;

    int checks = 0;
    int errors = 0;

    ramp_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .pos_out   (pos_out),
        .step_tick (step_tick),
        .running   (running)
    );

    always #5 clk = ~clk;

    function automatic logic [26:0] p3(input int a, input int b, input int c);
        return {9'(c), 9'(b), 9'(a)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [21:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        step();
        cmd_valid = 1'b0;
    endtask

    // Edges until step_tick is seen, or -1 if the bound expires.
    task automatic wait_tick(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!step_tick && n < limit);
        if (!step_tick) n = -1;
    endtask

    initial begin
        int n;
        logic [26:0] model;
        logic        over;

        // Reset values
        #3 rst_n = 1'b0;
        step();
        step();
        check("rst_pos", pos_out, p3(0, 120, 240));
        check("rst_tick", step_tick, 1'b0);
        check("rst_running", running, 1'b0);
        check("rst_ready", cmd_ready, 1'b1);
        rst_n = 1'b1;
        step();

        // SET_DELAY 3 in IDLE applies directly; START gives ticks every 4 cycles
        cmd(2'd2, 22'd3);
        check("idle_set_ready", cmd_ready, 1'b1);
        check("idle_set_running", running, 1'b0);
        cmd(2'd0, 22'd0);
        check("start_running", running, 1'b1);
        check("start_tick", step_tick, 1'b0);
        wait_tick(20, n);
        check("d3_first_period", n, 4);
        check("d3_first_pos", pos_out, p3(1, 121, 241));
        wait_tick(20, n);
        check("d3_second_period", n, 4);

        // SET_DELAY 7 two cycles after a tick
        step();
        cmd(2'd2, 22'd7);
        check("pend_ready_low", cmd_ready, 1'b0);
        step();
        check("pend_ready_still_low", cmd_ready, 1'b0);
        check("pend_no_tick_yet", step_tick, 1'b0);
        step();
        check("pend_old_delay_tick", step_tick, 1'b1);
        check("pend_ready_back", cmd_ready, 1'b1);
        check("pend_pos", pos_out, p3(3, 123, 243));
        wait_tick(20, n);
        check("d7_period_a", n, 8);
        wait_tick(20, n);
        check("d7_period_b", n, 8);

        // STOP exactly when counter == active_delay
        repeat (7) step();
        cmd(2'd1, 22'd0);
        check("stop_no_tick", step_tick, 1'b0);
        check("stop_running", running, 1'b0);
        check("stop_pos_hold", pos_out, p3(5, 125, 245));
        repeat (3) step();
        check("idle_no_tick", step_tick, 1'b0);
        check("idle_pos_hold", pos_out, p3(5, 125, 245));
        cmd(2'd0, 22'd0);
        check("restart_running", running, 1'b1);
        check("restart_edge_no_tick", step_tick, 1'b0);
        step();
        check("restart_tick_next", step_tick, 1'b1);
        check("restart_pos", pos_out, p3(6, 126, 246));

        // Delay 0, run ch0 up to 57, then ALIGN
        cmd(2'd1, 22'd0);
        cmd(2'd2, 22'd0);
        cmd(2'd0, 22'd0);
        repeat (51) step();
        check("d0_pos57", pos_out, p3(57, 177, 297));
        cmd(2'd3, 22'd0);
        check("align_pos", pos_out, p3(0, 120, 240));
        check("align_no_tick", step_tick, 1'b0);
        check("align_running", running, 1'b1);

        // 360 ticks at delay 0 from the aligned state
        over = 1'b0;
        for (int i = 1; i <= 360; i++) begin
            step();
            model = p3(i % 360, (120 + i) % 360, (240 + i) % 360);
            check($sformatf("wrap_n%0d", i), {step_tick, pos_out}, {1'b1, model});
            for (int k = 0; k < 3; k++) begin
                if (pos_out[9*k +: 9] > 9'd359) over = 1'b1;
            end
        end
        check("wrap_never_over_max", over, 1'b0);
        check("wrap_full_cycle", pos_out, p3(0, 120, 240));

        // Reset while RUN with a pending delay
        cmd(2'd1, 22'd0);
        check("stop2_no_tick", step_tick, 1'b0);
        cmd(2'd2, 22'd9);
        cmd(2'd0, 22'd0);
        step();
        cmd(2'd2, 22'd2);
        check("pend2_ready_low", cmd_ready, 1'b0);
        check("pend2_running", running, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_pos", pos_out, p3(0, 120, 240));
        check("arst_running", running, 1'b0);
        check("arst_ready", cmd_ready, 1'b1);
        check("arst_tick", step_tick, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        cmd(2'd0, 22'd0);
        wait_tick(50000, n);
        check("default_delay_period", n, 41667);
        check("default_delay_pos", pos_out, p3(1, 121, 241));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
